vec_unpack: RTL and testbench

VEC_UNPACK -- requirements
Module: vec_unpack

---
 rtl/vec_unpack.sv | 95 +++++++++
 tb/tb_vec_unpack.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_unpack.sv
// Word-to-element unpacker: takes NUM_ELEM packed elements per word and emits
// them one per cycle, element 0 first, with valid/ready handshakes on both sides.
module vec_unpack #(
  parameter int unsigned ELEM_W   = 10,
  parameter int unsigned NUM_ELEM = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ELEM_W*NUM_ELEM-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ELEM_W-1:0]            out_data,
  output logic                         out_last,
  output logic                         busy
);

  localparam int unsigned WORD_W = ELEM_W * NUM_ELEM;
  localparam int unsigned IDX_W  = $clog2(NUM_ELEM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              r_state;
  logic [WORD_W-1:0]   r_sb;
  logic [IDX_W-1:0]    r_idx;

  logic w_send;
  logic w_last;
  logic w_out_xfer;
  logic w_in_ready;
  logic w_in_xfer;

  // Handshake decode; in_ready opens on the last element so words chain without a bubble.
  assign w_send     = (r_state == SEND);
  assign w_last     = w_send && (r_idx == LAST_IDX);
  assign w_out_xfer = w_send && out_ready;
  assign w_in_ready = !rst && !clr && (!w_send || (out_ready && w_last));
  assign w_in_xfer  = in_valid && w_in_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = w_send;
  assign out_data  = r_sb[ELEM_W-1:0];
  assign out_last  = w_last;
  assign busy      = w_send;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sb    <= '0;
      r_idx   <= '0;
    end else if (clr) begin
      // sb is left as-is; it is reloaded before it is next observed as valid
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_xfer) begin
            r_sb    <= in_data;
            r_idx   <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_out_xfer) begin
            if (w_last) begin
              if (w_in_xfer) begin
                r_sb    <= in_data;
                r_idx   <= '0;
                r_state <= SEND;
              end else begin
                r_idx   <= '0;
                r_state <= IDLE;
              end
            end else begin
              r_sb  <= r_sb >> ELEM_W;
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_unpack.sv
// Directed self-checking bench for vec_unpack (ELEM_W=10, NUM_ELEM=8).
module tb_vec_unpack;

  localparam int unsigned EW = 10;
  localparam int unsigned NE = 8;
  localparam int unsigned WW = EW * NE;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vec_unpack #(.ELEM_W(EW), .NUM_ELEM(NE)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  // Word whose element k holds base+k
  function automatic logic [WW-1:0] mk(input int base);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < int'(NE); k++) w[k*EW +: EW] = EW'(base + k);
    return w;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data got %h want 0", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rst_out_last got %b want 0", out_last); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    next(); next();
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
    next();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_data = mk(1); out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_idle_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_idle_valid got %b want 0", out_valid); end
    next();
    in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < int'(NE); k++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid[%0d] got %b want 1", k, out_valid); end
      n_cmp++; if (out_data !== EW'(k + 1)) begin n_bad++; $display("FAIL basic_data[%0d] got %h want %h", k, out_data, EW'(k + 1)); end
      n_cmp++; if (out_last !== (k == 7)) begin n_bad++; $display("FAIL basic_last[%0d] got %b want %b", k, out_last, (k == 7)); end
      n_cmp++; if (in_ready !== (k == 7)) begin n_bad++; $display("FAIL basic_in_ready[%0d] got %b want %b", k, in_ready, (k == 7)); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy[%0d] got %b want 1", k, busy); end
      next();
    end
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_done_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_done_busy got %b want 0", busy); end
    next();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_data = mk(16'h10); out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_first_ready got %b want 1", in_ready); end
    next();
    for (int i = 0; i < 16; i++) begin
      in_valid = (i < 8);
      in_data  = (i < 8) ? mk(16'h20) : '0;
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== EW'((i < 8) ? (16'h10 + i) : (16'h20 + i - 8)))
        begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, out_data, EW'((i < 8) ? (16'h10 + i) : (16'h20 + i - 8))); end
      n_cmp++; if (in_ready !== ((i % 8) == 7)) begin n_bad++; $display("FAIL b2b_in_ready[%0d] got %b want %b", i, in_ready, ((i % 8) == 7)); end
      n_cmp++; if (out_last !== ((i % 8) == 7)) begin n_bad++; $display("FAIL b2b_last[%0d] got %b want %b", i, out_last, ((i % 8) == 7)); end
      next();
    end
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_done_valid got %b want 0", out_valid); end
    next();
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int e;
    pat = 4'b1001;
    e = 0;
    in_valid = 1'b1; in_data = mk(16'h100); out_ready = 1'b0;
    next();
    in_valid = 1'b0; in_data = '0;
    for (int c = 0; c < 40 && e < int'(NE); c++) begin
      out_ready = pat[c % 4];
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got %b want 1", c, out_valid); end
      n_cmp++; if (out_data !== EW'(16'h100 + e)) begin n_bad++; $display("FAIL bp_data[%0d] got %h want %h", c, out_data, EW'(16'h100 + e)); end
      n_cmp++; if (in_ready !== (out_ready && e == 7)) begin n_bad++; $display("FAIL bp_in_ready[%0d] got %b want %b", c, in_ready, (out_ready && e == 7)); end
      if (out_ready) e++;
      next();
    end
    #1;
    n_cmp++; if (e != int'(NE)) begin n_bad++; $display("FAIL bp_count got %0d want %0d", e, NE); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_done_valid got %b want 0", out_valid); end
    out_ready = 1'b1;
    next();
  endtask

  task automatic test_clr();
    in_valid = 1'b1; in_data = mk(16'h200); out_ready = 1'b1;
    next();
    in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (out_data !== EW'(16'h200 + k)) begin n_bad++; $display("FAIL clr_pre_data[%0d] got %h want %h", k, out_data, EW'(16'h200 + k)); end
      next();
    end
    clr = 1'b1; in_valid = 1'b1; in_data = mk(16'h50);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL clr_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_data !== EW'(16'h203)) begin n_bad++; $display("FAIL clr_cycle_data got %h want 203", out_data); end
    next();
    clr = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_after_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_after_busy got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_after_in_ready got %b want 1", in_ready); end
    next();
    in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < int'(NE); k++) begin
      #1;
      n_cmp++; if (out_data !== EW'(16'h50 + k)) begin n_bad++; $display("FAIL clr_new_data[%0d] got %h want %h", k, out_data, EW'(16'h50 + k)); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL clr_new_valid[%0d] got %b want 1", k, out_valid); end
      next();
    end
  endtask

  task automatic test_rst_mid();
    in_valid = 1'b1; in_data = mk(16'h300); out_ready = 1'b1;
    next();
    in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < 5; k++) next();
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rstmid_data got %h want 0", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rstmid_last got %b want 0", out_last); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_in_ready got %b want 0", in_ready); end
    next();
    rst = 1'b0; in_valid = 1'b1; in_data = '1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready_after got %b want 1", in_ready); end
    next();
    in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < int'(NE); k++) begin
      #1;
      n_cmp++; if (out_data !== 10'h3FF) begin n_bad++; $display("FAIL rstmid_new_data[%0d] got %h want 3ff", k, out_data); end
      n_cmp++; if (out_last !== (k == 7)) begin n_bad++; $display("FAIL rstmid_new_last[%0d] got %b want %b", k, out_last, (k == 7)); end
      next();
    end
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_done_valid got %b want 0", out_valid); end
    next();
  endtask

  // Packer model: groups the stream eight at a time, first sample into element 0
  task automatic test_round_trip();
    logic [EW-1:0] strm [24];
    logic [WW-1:0] words [3];
    int wi;
    int oi;
    for (int i = 0; i < 24; i++) begin
      strm[i] = EW'((i * 37 + 5) % 1024);
      words[i / 8][(i % 8) * EW +: EW] = strm[i];
    end
    wi = 0;
    oi = 0;
    for (int c = 0; c < 200 && oi < 24; c++) begin
      if (wi < 3) begin
        in_valid = 1'b1;
        in_data  = words[wi];
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      out_ready = ((c % 3) != 2);
      #1;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_data !== strm[oi]) begin n_bad++; $display("FAIL rt_data[%0d] got %h want %h", oi, out_data, strm[oi]); end
        oi++;
      end
      if (in_valid && in_ready) wi++;
      next();
    end
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    n_cmp++; if (oi != 24) begin n_bad++; $display("FAIL rt_count got %0d want 24", oi); end
    next();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_clr();
    test_rst_mid();
    test_round_trip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
